// File: rtl/rr_arbiter8.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Purpose  : Eight-requester round-robin arbiter. Turns a multi-hot request
//            vector into a registered one-hot grant plus its binary index and
//            holds the grant until the owner releases it.
// Options  : ARB_TIMEOUT_EN - when defined, a hold counter forcibly reclaims
//            a grant held for TIMEOUT cycles and pulses `timeout`.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Reject out-of-range hold limits at elaboration time.
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("rr_arbiter8: TIMEOUT must lie in 2..255");
  end

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_vld_q, gnt_vld_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic       owner_req;
  logic       expire;
  logic       release_grant;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] C_HOLD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Circular priority scan starting at ptr; the lowest offset from ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr_q + 3'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 3'(i);
      end
    end
  end

  // Release conditions seen while a grant is held.
  always_comb begin
    owner_req = req[gnt_idx_q];
`ifdef ARB_TIMEOUT_EN
    expire    = (cnt_q == C_HOLD_LAST);
`else
    expire    = 1'b0;
`endif
    release_grant = done || !owner_req || expire;
  end

  // Next-state and next-output computation for the IDLE/GRANT machine.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d   = ST_GRANT;
          gnt_d     = 8'b1 << win_idx;
          gnt_idx_d = win_idx;
          gnt_vld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end
      end
      ST_GRANT: begin
        if (release_grant) begin
          // Always drop back to IDLE so consecutive grants get a bubble.
          state_d   = ST_IDLE;
          ptr_d     = gnt_idx_q + 3'd1;
          gnt_d     = 8'd0;
          gnt_idx_d = 3'd0;
          gnt_vld_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          // Flag only releases caused solely by the hold limit.
          timeout_d = expire && !done && owner_req;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      gnt_q     <= 8'd0;
      gnt_idx_q <= 3'd0;
      gnt_vld_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter8
// Purpose  : Self-checking bench for rr_arbiter8. A behavioural reference
//            model pushes the expected outputs for every driven cycle; they
//            are popped and compared after the clock edge.
// Options  : ARB_TIMEOUT_EN - exercises the forced-release path (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam bit TB_TO_EN   = 1'b1;
`else
  localparam int TB_TIMEOUT = 16;
  localparam bit TB_TO_EN   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit         m_busy;
  logic [2:0] m_ptr;
  logic [2:0] m_idx;
  int         m_cnt;
  logic       m_to;

  // Expected {timeout, gnt_vld, gnt_idx, gnt}
  logic [12:0] exp_q[$];

  rr_arbiter8 #(
    .TIMEOUT(TB_TIMEOUT)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_ptr  = 3'd0;
    m_idx  = 3'd0;
    m_cnt  = 0;
    m_to   = 1'b0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic [7:0] r, input logic d);
    logic [2:0] j;
    logic       lim;
    m_to = 1'b0;
    if (!m_busy) begin
      for (int i = 0; i < 8; i++) begin
        j = m_ptr + 3'(i);
        if (!m_busy && r[j]) begin
          m_busy = 1'b1;
          m_idx  = j;
          m_cnt  = 0;
        end
      end
    end else begin
      lim = TB_TO_EN && (m_cnt == TB_TIMEOUT - 1);
      if (d || !r[m_idx] || lim) begin
        m_to   = lim && !d && r[m_idx];
        m_ptr  = m_idx + 3'd1;
        m_busy = 1'b0;
        m_idx  = 3'd0;
      end else begin
        m_cnt++;
      end
    end
    exp_q.push_back({m_to, m_busy, m_idx, (m_busy ? (8'b1 << m_idx) : 8'h00)});
  endtask

  // Drive one cycle of stimulus, then compare against the scoreboard.
  task automatic cycle(input string tag, input logic [7:0] r, input logic d);
    logic [12:0] e;
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'({timeout, gnt_vld, gnt_idx, gnt}), 32'(e));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    model_reset();

    // Reset held with every agent requesting
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    chk("rst_vld", 32'(gnt_vld), 32'h0);
    chk("rst_to",  32'(timeout), 32'h0);
    rst_n = 1'b1;
    cycle("first", 8'hFF, 1'b0);
    chk("first_gnt", 32'(gnt), 32'h01);

    // Rotation across all agents with a bubble between grants
    cycle("rot_rel", 8'hFF, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      cycle("rot_gnt", 8'hFF, 1'b0);
      chk("rot_idx", 32'(gnt_idx), 32'(k % 8));
      cycle("rot_rel", 8'hFF, 1'b1);
    end

    // Skip and wrap from ptr = 6
    cycle("sw_g5", 8'h20, 1'b0);
    cycle("sw_r5", 8'h20, 1'b1);
    cycle("sw_g0", 8'h09, 1'b0);
    chk("sw_idx0", 32'(gnt_idx), 32'd0);
    cycle("sw_r0", 8'h09, 1'b1);
    cycle("sw_g3", 8'h09, 1'b0);
    chk("sw_idx3", 32'(gnt_idx), 32'd3);
    cycle("nonowner", 8'hF8, 1'b0);
    cycle("sw_r3", 8'h09, 1'b1);

    // Owner withdrawal, combined release, done while idle
    cycle("wd_g4", 8'h30, 1'b0);
    chk("wd_idx4", 32'(gnt_idx), 32'd4);
    cycle("wd_drop", 8'h20, 1'b0);
    chk("wd_vld", 32'(gnt_vld), 32'd0);
    cycle("wd_g5", 8'h30, 1'b0);
    chk("wd_idx5", 32'(gnt_idx), 32'd5);
    cycle("both_rel", 8'h00, 1'b1);
    cycle("idle_done", 8'h00, 1'b1);
    cycle("after_both", 8'hFF, 1'b0);
    chk("after_both_idx", 32'(gnt_idx), 32'd6);
    cycle("after_rel", 8'hFF, 1'b1);

    // Asynchronous reset between edges while agent 5 owns the slot
    cycle("ar_g5", 8'h20, 1'b0);
    cycle("ar_hold", 8'h20, 1'b0);
    chk("ar_idx5", 32'(gnt_idx), 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_idx", 32'(gnt_idx), 32'h0);
    chk("ar_vld", 32'(gnt_vld), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("ar_post", 8'hFF, 1'b0);
    chk("ar_post_idx", 32'(gnt_idx), 32'd0);
    cycle("ar_rel", 8'hFF, 1'b1);

    // Long hold by agent 2 with agent 3 also requesting
    cycle("hold_g2", 8'h0C, 1'b0);
    chk("hold_idx2", 32'(gnt_idx), 32'd2);
`ifdef ARB_TIMEOUT_EN
    repeat (3) cycle("to_hold", 8'h0C, 1'b0);
    cycle("to_rel", 8'h0C, 1'b0);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_vld", 32'(gnt_vld), 32'd0);
    cycle("to_next", 8'h0C, 1'b0);
    chk("to_next_idx", 32'(gnt_idx), 32'd3);
    chk("to_cleared", 32'(timeout), 32'd0);
`else
    repeat (120) cycle("hold", 8'h0C, 1'b0);
    chk("hold_vld", 32'(gnt_vld), 32'd1);
    chk("hold_idx", 32'(gnt_idx), 32'd2);
`endif
    cycle("end_rel", 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares one resource slot between eight agents. It turns a multi-hot request vector into a registered one-hot grant and its 3-bit encoded index, so downstream logic gets a clean, single-winner select. It sits in front of the 8:3 encoding/select datapath: it sequences ownership fairly and holds each grant until the owner releases it. An optional timeout forcibly reclaims a stuck grant.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles one grant may be held. Used only when `ARB_TIMEOUT_EN` is defined. Legal range 2..255.

Ports (clock and reset first):
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  8  request vector; bit n high = agent n requests the slot.
- `done`  input  1  release strobe from the current owner; sampled only in GRANT.
- `gnt`  output  8  registered one-hot grant; all zero when no grant is active.
- `gnt_idx`  output  3  binary index of the granted agent; 0 when `gnt_vld` = 0.
- `gnt_vld`  output  1  high while a grant is held.
- `timeout`  output  1  one-cycle pulse on forced release; constant 0 when the macro is undefined.

## Operation
- State machine with two states, IDLE and GRANT. Internal 3-bit round-robin pointer `ptr`.
- **IDLE**: if `req` ≠ 0, select the first set bit scanning circularly from `ptr` upward (`ptr`, `ptr`+1, …, 7, 0, …, `ptr`−1).
  - Register `gnt` = one-hot of the winner, `gnt_idx` = winner index, `gnt_vld` = 1.
  - Move to GRANT.
  - If `req` = 0, stay in IDLE.
- **GRANT**: hold `gnt` and `gnt_idx` stable. Release when any of these holds:
  - `done` = 1, or
  - `req[gnt_idx]` = 0 (the owner withdraws), or
  - the timeout expires (macro only).
- **On release**:
  - `ptr` ← `gnt_idx` + 1, 3-bit modulo, so 7 wraps to 0.
  - Clear `gnt` to 0, `gnt_idx` to 0, `gnt_vld` to 0.
  - Return to IDLE.
- IDLE always lasts at least one cycle between grants. This guarantees a bubble, so no two grants are ever back-to-back.
- `gnt` is never multi-hot. `gnt_idx` always equals the encoding of `gnt`.
- A change in request bits of non-owners during GRANT has no effect.
- Reset values: `gnt` = 0, `gnt_idx` = 0, `gnt_vld` = 0, `timeout` = 0, `ptr` = 0, state = IDLE.

## Timing
- **Grant latency**: `req` sampled at edge k in IDLE gives `gnt` / `gnt_vld` valid after edge k (1 cycle).
- **Release latency**: `done` sampled at edge k gives `gnt_vld` low after edge k. The earliest next grant is after edge k+1.
- **`done` in IDLE**: ignored.
- **`done` together with owner withdrawal**: a single release; `ptr` advances once.
- **Reset mid-grant**: `rst_n` low clears all outputs immediately (asynchronously), without waiting for `clk`. Arbitration restarts from `ptr` = 0 after the first rising edge with `rst_n` high.
- **Worst-case wait**: a requester holding `req` high waits at most 7 grants.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- **Defined**:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the count reaches `TIMEOUT` − 1 without release, the grant is released at the next edge, following the normal release rules.
  - `timeout` pulses high for the single cycle in which `gnt_vld` first reads 0.
- **Undefined**:
  - No counter is built; a grant is held indefinitely until `done` or the owner withdraws.
  - `timeout` is tied to 0.

## Test plan
- **Reset**: hold `rst_n` = 0 with `req` = 8'hFF -> `gnt` = 0, `gnt_idx` = 0, `gnt_vld` = 0. Release reset -> 1 cycle later `gnt` = 8'b00000001, `gnt_idx` = 0.
- **Rotation**: `req` = 8'hFF, pulse `done` after each grant -> `gnt_idx` sequence 0,1,2,…,7,0, with one idle cycle between grants.
- **Skip and wrap**: `ptr` = 6 (after agent 5 releases), `req` = 8'b00001001 -> `gnt_idx` = 0. After release, the next grant goes to `gnt_idx` = 3.
- **Withdrawal**: agent 4 granted, drop `req[4]` with `done` = 0 -> `gnt_vld` = 0 the next cycle. The next winner is agent 5 if it is requesting.
- **Async reset mid-grant**: assert `rst_n` = 0 between clock edges while `gnt_idx` = 5 -> outputs go to 0 immediately. The first grant after reset starts the scan at agent 0.
- **Timeout** (macro defined, `TIMEOUT` = 4): agent 2 holds `req` with no `done` -> grant held for 4 cycles, then `gnt_vld` = 0 with `timeout` = 1 for one cycle. The next grant goes to agent 3 if it is requesting. With the macro undefined, the grant persists for 100+ cycles and `timeout` stays 0.
